// File: rtl/grad_serial_arb.sv
// grad_serial_arb: round-robin arbiter sharing one gradient DAC serializer
// between N_REQ word sources. Each source owns a one-word holding slot whose
// full flag is returned as that source's busy. A three-state FSM issues one
// start pulse per word and follows the serializer busy handshake. Dropped
// words and missing serializer acknowledges are latched as sticky flags.
//
// Ports:
//   S_AXI_ACLK     clock, rising edge
//   S_AXI_ARESETN  asynchronous active-low reset
//   req_data_i     packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid_i    per-requester one-cycle word strobe
//   req_busy_o     per-requester slot full
//   ser_data_o     word presented to the serializer, held until next grant
//   ser_src_o      requester index owning ser_data_o
//   ser_start_o    one-cycle start pulse to the serializer
//   ser_busy_i     serializer busy
//   overrun_o      sticky: word arrived while slot i was full
//   ack_err_o      sticky: serializer did not acknowledge within ACK_TO cycles
//   clr_err_i      one-cycle clear of the sticky flags
//   idle_o         FSM idle and all slots empty (combinational)
module grad_serial_arb #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACK_TO     = 4,
    localparam int unsigned SRC_W     = $clog2(N_REQ)
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_busy_o,
    output logic [DATA_WIDTH-1:0]       ser_data_o,
    output logic [SRC_W-1:0]            ser_src_o,
    output logic                        ser_start_o,
    input  logic                        ser_busy_i,
    output logic [N_REQ-1:0]            overrun_o,
    output logic                        ack_err_o,
    input  logic                        clr_err_i,
    output logic                        idle_o
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_start_nxt;
    logic                    w_grant_en;
    logic                    w_ack_err_set;

    logic [DATA_WIDTH-1:0]   r_slot [N_REQ];
    logic [N_REQ-1:0]        r_full;
    logic [SRC_W-1:0]        r_ptr;
    logic [SRC_W-1:0]        w_grant;
    logic                    w_any;
    logic [N_REQ-1:0]        w_gnt_vec;
    logic [N_REQ-1:0]        w_ovr_set;
    logic [SRC_W-1:0]        w_ptr_nxt;

    logic [DATA_WIDTH-1:0]   r_ser_data;
    logic [SRC_W-1:0]        r_ser_src;
    logic                    r_ser_start;
    logic [N_REQ-1:0]        r_overrun;
    logic                    r_ack_err;

    // Round-robin search: first full slot at ptr, ptr+1, ... modulo N_REQ
    always_comb begin
        logic [SRC_W-1:0] idx;
        w_grant = '0;
        w_any   = 1'b0;
        idx     = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = SRC_W'((int'(r_ptr) + k) % int'(N_REQ));
            if (!w_any && r_full[idx]) begin
                w_grant = idx;
                w_any   = 1'b1;
            end
        end
    end

    assign w_gnt_vec = w_grant_en ? (N_REQ'(1) << w_grant) : '0;
    assign w_ovr_set = req_valid_i & r_full & ~w_gnt_vec;
    assign w_ptr_nxt = (int'(w_grant) + 1 == int'(N_REQ)) ? '0 : w_grant + SRC_W'(1);

    // FSM state, ack counter and serializer-side registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ser_start <= 1'b0;
            r_ser_data  <= '0;
            r_ser_src   <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ser_start <= w_start_nxt;
            if (w_grant_en) begin
                r_ser_data <= r_slot[w_grant];
                r_ser_src  <= w_grant;
                r_ptr      <= w_ptr_nxt;
            end
        end
    end

    // Next-state: grant only when the serializer is free; a missing ack drops the word
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_start_nxt   = 1'b0;
        w_grant_en    = 1'b0;
        w_ack_err_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && !ser_busy_i) begin
                    w_grant_en  = 1'b1;
                    w_start_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ser_busy_i) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_cnt_nxt == CNT_W'(ACK_TO)) begin
                        w_ack_err_set = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end
            ST_BUSY: begin
                if (!ser_busy_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Holding slots: a slot being granted this cycle can accept a new word
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_full <= '0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (req_valid_i[i] && (!r_full[i] || w_gnt_vec[i])) begin
                    r_slot[i] <= req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    r_full[i] <= 1'b1;
                end else if (w_gnt_vec[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky flags: a set event in the clear cycle keeps the flag high
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_overrun <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_overrun <= (clr_err_i ? '0 : r_overrun) | w_ovr_set;
            r_ack_err <= (clr_err_i ? 1'b0 : r_ack_err) | w_ack_err_set;
        end
    end

    assign req_busy_o  = r_full;
    assign ser_data_o  = r_ser_data;
    assign ser_src_o   = r_ser_src;
    assign ser_start_o = r_ser_start;
    assign overrun_o   = r_overrun;
    assign ack_err_o   = r_ack_err;
    assign idle_o      = (r_state == ST_IDLE) && !(|r_full);

endmodule
